range_summary: RTL and testbench

Downstream consumer of the Collatz range stage. When the range stage reports `done`, this block walks its count RAM through the address/count read port and finds the largest count, its index and the sum of all counts. It then converts the maximum to packed BCD for the seven-segment display driver. It replaces manual key-by-key readout with one automatic summary per run.

---
 rtl/range_summary.sv | 162 ++++++++++++++++
 tb/tb_range_summary.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/range_summary.sv
// Post-run summary of the Collatz range RAM: scans every word for max, index of max and sum,
// then converts the max to packed BCD for the display driver.
module range_summary #(
  parameter int unsigned RAM_WORDS     = 16,
  parameter int unsigned RAM_ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        range_done,
  input  logic [15:0]                 range_count,
  output logic [RAM_ADDR_BITS-1:0]    rd_addr,
  output logic [15:0]                 max_count,
  output logic [RAM_ADDR_BITS-1:0]    max_index,
  output logic [16+RAM_ADDR_BITS-1:0] sum,
  output logic [19:0]                 max_bcd,
  output logic                        busy,
  output logic                        valid
);

  localparam int unsigned CW     = 16;
  localparam int unsigned SW     = CW + RAM_ADDR_BITS;
  localparam int unsigned BW     = 20;
  localparam int unsigned DIGITS = BW / 4;
  localparam int unsigned BIT_W  = 4;
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);
  localparam logic [BIT_W-1:0]         LAST_BIT  = BIT_W'(CW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_CONV,
    S_HOLD
  } state_t;

  state_t state, state_nx;

  logic                     done_q;
  logic                     trigger_c;
  logic                     samp_vld;
  logic [RAM_ADDR_BITS-1:0] samp_addr;
  logic [CW-1:0]            max_r;
  logic [RAM_ADDR_BITS-1:0] idx_r;
  logic [SW-1:0]            acc_r;
  logic [BW-1:0]            bcd_r;
  logic [BW-1:0]            bcd_adj_c;
  logic [BW-1:0]            bcd_nx_c;
  logic [BIT_W-1:0]         bit_cnt;
  logic [BIT_W-1:0]         bit_sel_c;
  logic                     busy_nx_c;

  assign trigger_c = range_done & ~done_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; losing range_done mid-run abandons the scan
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (trigger_c) state_nx = S_SCAN;
      S_SCAN: begin
        if (!range_done)              state_nx = S_IDLE;
        else if (rd_addr == LAST_ADDR) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!range_done) state_nx = S_IDLE;
        else             state_nx = S_CONV;
      end
      S_CONV: begin
        if (!range_done)              state_nx = S_IDLE;
        else if (bit_cnt == LAST_BIT) state_nx = S_HOLD;
      end
      S_HOLD:  if (!range_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy_nx_c = (state_nx == S_SCAN) || (state_nx == S_DRAIN) || (state_nx == S_CONV);

  // One double-dabble step: add 3 to digits >= 5, then shift in the next max bit
  always_comb begin
    bcd_adj_c = bcd_r;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_adj_c[4*d +: 4] >= 4'd5) bcd_adj_c[4*d +: 4] = bcd_adj_c[4*d +: 4] + 4'd3;
    end
    bit_sel_c = LAST_BIT - bit_cnt;
    bcd_nx_c  = {bcd_adj_c[BW-2:0], max_r[bit_sel_c]};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q    <= 1'b0;
      samp_vld  <= 1'b0;
      samp_addr <= '0;
      rd_addr   <= '0;
      max_r     <= '0;
      idx_r     <= '0;
      acc_r     <= '0;
      bcd_r     <= '0;
      bit_cnt   <= '0;
      max_count <= '0;
      max_index <= '0;
      sum       <= '0;
      max_bcd   <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      done_q    <= range_done;
      busy      <= busy_nx_c;
      samp_vld  <= (state == S_SCAN);
      samp_addr <= rd_addr;

      if (state == S_SCAN && state_nx == S_SCAN) rd_addr <= rd_addr + 1'b1;
      else                                      rd_addr <= '0;

      // Returned word for the address presented one cycle earlier; ties keep the lower index
      if (samp_vld && (state == S_SCAN || state == S_DRAIN)) begin
        acc_r <= acc_r + SW'(range_count);
        if (range_count > max_r) begin
          max_r <= range_count;
          idx_r <= samp_addr;
        end
      end

      case (state)
        S_IDLE: begin
          if (trigger_c) begin
            max_r <= '0;
            idx_r <= '0;
            acc_r <= '0;
            valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          bcd_r   <= '0;
          bit_cnt <= '0;
        end
        S_CONV: begin
          bcd_r   <= bcd_nx_c;
          bit_cnt <= bit_cnt + 1'b1;
          if (state_nx == S_HOLD) begin
            max_count <= max_r;
            max_index <= idx_r;
            sum       <= acc_r;
            max_bcd   <= bcd_nx_c;
            valid     <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!range_done) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_range_summary.sv
// Directed bench for range_summary with a 1-cycle-read upstream RAM model.
module tb_range_summary;

  logic        clk = 1'b0;
  logic        reset;
  logic        range_done;
  logic [15:0] range_count;
  logic [3:0]  rd_addr;
  logic [15:0] max_count;
  logic [3:0]  max_index;
  logic [19:0] sum;
  logic [19:0] max_bcd;
  logic        busy;
  logic        valid;

  logic [15:0] mem [16];
  int          n_checks = 0;
  int          n_fails  = 0;

  range_summary #(.RAM_WORDS(16), .RAM_ADDR_BITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .range_done  (range_done),
    .range_count (range_count),
    .rd_addr     (rd_addr),
    .max_count   (max_count),
    .max_index   (max_index),
    .sum         (sum),
    .max_bcd     (max_bcd),
    .busy        (busy),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  // Upstream RAM: registered read data, one cycle after the address
  always @(posedge clk) range_count <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise range_done, then check timing and results; leaves range_done high in HOLD
  task automatic do_scan(input string tag, input logic [15:0] emax, input logic [3:0] eidx,
                         input logic [19:0] esum, input logic [19:0] ebcd);
    range_done = 1'b1;
    step(1);
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    step(32);
    check({tag, ".valid_early"}, 32'(valid), 32'd0);
    check({tag, ".busy_c33"}, 32'(busy), 32'd1);
    step(2);
    check({tag, ".valid"}, 32'(valid), 32'd1);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".max"}, 32'(max_count), 32'(emax));
    check({tag, ".idx"}, 32'(max_index), 32'(eidx));
    check({tag, ".sum"}, 32'(sum), 32'(esum));
    check({tag, ".bcd"}, 32'(max_bcd), 32'(ebcd));
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
  endtask

  task automatic drop_done(input string tag, input logic [15:0] emax);
    range_done = 1'b0;
    step(2);
    check({tag, ".valid_fall"}, 32'(valid), 32'd0);
    check({tag, ".max_kept"}, 32'(max_count), 32'(emax));
  endtask

  initial begin
    int valid_seen;
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
    reset      = 1'b1;
    range_done = 1'b0;
    step(2);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.max", 32'(max_count), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.bcd", 32'(max_bcd), 32'd0);
    check("rst.addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    step(2);

    do_scan("ramp", 16'd16, 4'd15, 20'd136, 20'h00016);
    drop_done("ramp", 16'd16);

    for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    do_scan("zero", 16'd0, 4'd0, 20'd0, 20'h00000);
    drop_done("zero", 16'd0);

    for (int i = 0; i < 16; i++) mem[i] = 16'd1;
    mem[3] = 16'd7;
    mem[9] = 16'd7;
    do_scan("tie", 16'd7, 4'd3, 20'd28, 20'h00007);
    drop_done("tie", 16'd7);

    for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
    do_scan("full", 16'd65535, 4'd0, 20'd1048560, 20'h65535);
    drop_done("full", 16'd65535);

    // Abort mid-scan: no valid, results untouched, then a fresh scan with new data
    for (int i = 0; i < 16; i++) mem[i] = 16'd2;
    range_done = 1'b1;
    step(1);
    step(10);
    range_done = 1'b0;
    step(1);
    check("abort.busy", 32'(busy), 32'd0);
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (valid) valid_seen++;
    end
    check("abort.no_valid", 32'(valid_seen), 32'd0);
    check("abort.max_kept", 32'(max_count), 32'd65535);
    for (int i = 0; i < 16; i++) mem[i] = 16'(3 * i);
    do_scan("rescan", 16'd45, 4'd15, 20'd360, 20'h00045);
    drop_done("rescan", 16'd45);

    // Reset during CONV with range_done held high
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
    range_done = 1'b1;
    step(1);
    step(20);
    check("rstconv.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step(1);
    check("rstconv.valid", 32'(valid), 32'd0);
    check("rstconv.busy", 32'(busy), 32'd0);
    check("rstconv.max", 32'(max_count), 32'd0);
    check("rstconv.sum", 32'(sum), 32'd0);
    check("rstconv.bcd", 32'(max_bcd), 32'd0);
    reset = 1'b0;
    step(33);
    check("rstconv.valid_early", 32'(valid), 32'd0);
    step(2);
    check("rstconv.valid_late", 32'(valid), 32'd1);
    check("rstconv.max_late", 32'(max_count), 32'd16);
    check("rstconv.sum_late", 32'(sum), 32'd136);
    range_done = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
